// File: rtl/upower_ctrl_pkg.sv
// Shared encodings for the uPower multi-cycle controller: FSM states, opcode/XO
// values, ALU operation codes and bit positions inside the dp_ctrl bundle.
package upower_ctrl_pkg;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LD  = 2'd1,
    CLS_STD = 2'd2
  } iclass_e;

  localparam logic [5:0] OP_X    = 6'd31;
  localparam logic [5:0] OP_ADDI = 6'd14;
  localparam logic [5:0] OP_ANDI = 6'd28;
  localparam logic [5:0] OP_ORI  = 6'd24;
  localparam logic [5:0] OP_LD   = 6'd58;
  localparam logic [5:0] OP_STD  = 6'd62;

  localparam logic [9:0] XO_ADD  = 10'd266;
  localparam logic [9:0] XO_SUBF = 10'd40;
  localparam logic [9:0] XO_AND  = 10'd28;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam int DP_ALU_OP_LSB = 9;
  localparam int DP_REG_DST    = 8;
  localparam int DP_REG1       = 7;
  localparam int DP_REG2       = 6;
  localparam int DP_ALU_SRC    = 5;
  localparam int DP_MEM_TO_REG = 4;
  localparam int DP_REG_WRITE  = 3;
  localparam int DP_MEM_READ   = 2;
  localparam int DP_MEM_WRITE  = 1;
  localparam int DP_IMM_DS     = 0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_dst;
    logic       reg1;
    logic       reg2;
    logic       alu_src;
    logic       mem_to_reg;
    logic       imm_ds;
    iclass_e    cls;
    logic       legal;
  } decode_t;

endpackage

// File: rtl/upower_multicycle_ctrl_if.sv
// Instruction/data memory req-ready handshake bundle; the controller is the master.
interface upower_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;

  modport master (output imem_req, input imem_ready, output dmem_req, input dmem_ready);
  modport slave  (input imem_req, output imem_ready, input dmem_req, output dmem_ready);
endinterface

// File: rtl/upower_ctrl_decode.sv
// Combinational instruction decoder: (opcode, xo) -> datapath mux fields,
// instruction class and a legal flag.
module upower_ctrl_decode
  import upower_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [9:0] i_xo,
  output decode_t    o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_X: begin
        o_dec.reg2 = 1'b1;
        case (i_xo)
          XO_ADD:  begin o_dec.alu_op = ALU_ADD; o_dec.reg1 = 1'b1; o_dec.legal = 1'b1; end
          XO_SUBF: begin o_dec.alu_op = ALU_SUB; o_dec.reg1 = 1'b1; o_dec.legal = 1'b1; end
          XO_AND:  begin o_dec.alu_op = ALU_AND; o_dec.reg_dst = 1'b1; o_dec.legal = 1'b1; end
          default: o_dec.legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        o_dec.alu_op  = ALU_ADD;
        o_dec.reg1    = 1'b1;
        o_dec.alu_src = 1'b1;
        o_dec.legal   = 1'b1;
      end
      OP_ANDI: begin
        o_dec.alu_op  = ALU_AND;
        o_dec.reg_dst = 1'b1;
        o_dec.alu_src = 1'b1;
        o_dec.legal   = 1'b1;
      end
      OP_ORI: begin
        o_dec.alu_op  = ALU_OR;
        o_dec.reg_dst = 1'b1;
        o_dec.alu_src = 1'b1;
        o_dec.legal   = 1'b1;
      end
      // ld/std use the DS-form displacement and always compute an address with add
      OP_LD: begin
        o_dec.alu_op     = ALU_ADD;
        o_dec.reg1       = 1'b1;
        o_dec.alu_src    = 1'b1;
        o_dec.mem_to_reg = 1'b1;
        o_dec.imm_ds     = 1'b1;
        o_dec.cls        = CLS_LD;
        o_dec.legal      = 1'b1;
      end
      OP_STD: begin
        o_dec.alu_op  = ALU_ADD;
        o_dec.reg1    = 1'b1;
        o_dec.alu_src = 1'b1;
        o_dec.imm_ds  = 1'b1;
        o_dec.cls     = CLS_STD;
        o_dec.legal   = 1'b1;
      end
      default: o_dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/upower_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the uPower datapath with
// bounded memory handshakes, sticky error flags and a retired-instruction counter.
module upower_multicycle_ctrl
  import upower_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CW          = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               i_opcode,
  input  logic [9:0]               i_xo,
  upower_multicycle_ctrl_if.master bus,
  output logic                     o_ir_load,
  output logic                     o_pc_write,
  output logic [12:0]              o_dp_ctrl,
  output logic [2:0]               o_state,
  output logic                     o_illegal,
  output logic                     o_bus_err,
  output logic [CW-1:0]            o_retire_cnt
);

  localparam int            WW        = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_e        r_state;
  iclass_e       r_cls;
  logic [3:0]    r_alu_op;
  logic          r_reg_dst, r_reg1, r_reg2, r_alu_src, r_mem_to_reg, r_imm_ds;
  logic [WW-1:0] r_wait;
  logic          r_illegal, r_bus_err;
  logic [CW-1:0] r_retire;
  decode_t       w_dec;
  logic          w_imem_hit, w_dmem_hit;

  upower_ctrl_decode u_decode (
    .i_opcode (i_opcode),
    .i_xo     (i_xo),
    .o_dec    (w_dec)
  );

  assign w_imem_hit = (r_state == S_FETCH) && bus.imem_ready;
  assign w_dmem_hit = (r_state == S_MEM) && bus.dmem_ready;

  // Sequencer: state, latched decode fields, wait/retire counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_START;
      r_cls        <= CLS_ALU;
      r_alu_op     <= 4'b0000;
      r_reg_dst    <= 1'b0;
      r_reg1       <= 1'b0;
      r_reg2       <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_imm_ds     <= 1'b0;
      r_wait       <= '0;
      r_illegal    <= 1'b0;
      r_bus_err    <= 1'b0;
      r_retire     <= '0;
    end else begin
      case (r_state)
        S_START: begin
          r_wait  <= '0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          // a ready arriving in the timeout cycle still completes the fetch
          if (bus.imem_ready) begin
            r_state <= S_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            r_bus_err <= 1'b1;
            r_state   <= S_TRAP;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_DECODE: begin
          if (w_dec.legal) begin
            r_cls        <= w_dec.cls;
            r_alu_op     <= w_dec.alu_op;
            r_reg_dst    <= w_dec.reg_dst;
            r_reg1       <= w_dec.reg1;
            r_reg2       <= w_dec.reg2;
            r_alu_src    <= w_dec.alu_src;
            r_mem_to_reg <= w_dec.mem_to_reg;
            r_imm_ds     <= w_dec.imm_ds;
            r_state      <= S_EXEC;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_TRAP;
          end
        end
        S_EXEC: begin
          r_wait  <= '0;
          r_state <= (r_cls == CLS_ALU) ? S_WB : S_MEM;
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            r_wait <= '0;
            if (r_cls == CLS_LD) begin
              r_state <= S_WB;
            end else begin
              r_retire <= r_retire + CW'(1);
              r_state  <= S_FETCH;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_bus_err <= 1'b1;
            r_state   <= S_TRAP;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_WB: begin
          r_wait   <= '0;
          r_retire <= r_retire + CW'(1);
          r_state  <= S_FETCH;
        end
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Request, strobe and dp_ctrl decode from the registered state and fields
  always_comb begin
    bus.imem_req = (r_state == S_FETCH);
    bus.dmem_req = (r_state == S_MEM);
    o_ir_load    = w_imem_hit;
    o_pc_write   = w_imem_hit;
    o_dp_ctrl    = 13'd0;
    o_dp_ctrl[DP_ALU_OP_LSB +: 4] = r_alu_op;
    o_dp_ctrl[DP_REG_DST]    = r_reg_dst;
    o_dp_ctrl[DP_REG1]       = r_reg1;
    o_dp_ctrl[DP_REG2]       = r_reg2;
    o_dp_ctrl[DP_ALU_SRC]    = r_alu_src;
    o_dp_ctrl[DP_MEM_TO_REG] = r_mem_to_reg;
    o_dp_ctrl[DP_REG_WRITE]  = (r_state == S_WB);
    o_dp_ctrl[DP_MEM_READ]   = (r_state == S_MEM) && (r_cls == CLS_LD);
    o_dp_ctrl[DP_MEM_WRITE]  = (r_state == S_MEM) && (r_cls == CLS_STD);
    o_dp_ctrl[DP_IMM_DS]     = r_imm_ds;
  end

  assign o_state      = r_state;
  assign o_illegal    = r_illegal;
  assign o_bus_err    = r_bus_err;
  assign o_retire_cnt = r_retire;

endmodule

// File: tb/tb_upower_multicycle_ctrl.sv
// Directed bench for upower_multicycle_ctrl (MEM_TIMEOUT=4, CW=4): per-cycle
// expected output tables for each scenario, compared inline in each task.
module tb_upower_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  i_opcode;
  logic [9:0]  i_xo;
  logic        o_ir_load, o_pc_write, o_illegal, o_bus_err;
  logic [12:0] o_dp_ctrl;
  logic [2:0]  o_state;
  logic [3:0]  o_retire_cnt;
  int          checks;
  int          errors;

  upower_multicycle_ctrl_if mem ();

  upower_multicycle_ctrl #(.MEM_TIMEOUT(4), .CW(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_opcode     (i_opcode),
    .i_xo         (i_xo),
    .bus          (mem),
    .o_ir_load    (o_ir_load),
    .o_pc_write   (o_pc_write),
    .o_dp_ctrl    (o_dp_ctrl),
    .o_state      (o_state),
    .o_illegal    (o_illegal),
    .o_bus_err    (o_bus_err),
    .o_retire_cnt (o_retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dp_ctrl = {alu_op[3:0], reg_dst, reg1, reg2, alu_src, mem_to_reg, reg_write, mem_read, mem_write, imm_ds}
  localparam logic [12:0] E_ADDI = 13'b0010_0_1_0_1_0_000_0;
  localparam logic [12:0] E_LD   = 13'b0010_0_1_0_1_1_000_1;
  localparam logic [12:0] E_STD  = 13'b0010_0_1_0_1_0_000_1;
  localparam logic [12:0] E_AND  = 13'b0000_1_0_1_0_0_000_0;
  localparam logic [12:0] E_SUBF = 13'b0110_0_1_1_0_0_000_0;
  localparam logic [12:0] E_ADD  = 13'b0010_0_1_1_0_0_000_0;
  localparam logic [12:0] E_ANDI = 13'b0000_1_0_0_1_0_000_0;
  localparam logic [12:0] E_ORI  = 13'b0001_1_0_0_1_0_000_0;
  localparam logic [12:0] RW = 13'b0000_0_0_0_0_0_100_0;
  localparam logic [12:0] MR = 13'b0000_0_0_0_0_0_010_0;
  localparam logic [12:0] MW = 13'b0000_0_0_0_0_0_001_0;

  typedef struct packed {
    logic [5:0]  op;
    logic [9:0]  xo;
    logic        imr;
    logic        dmr;
    logic [2:0]  st;
    logic [12:0] dp;
    logic        imreq;
    logic        dmreq;
    logic        irl;
    logic [3:0]  rc;
    logic        il;
    logic        be;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] op, input logic [9:0] xo, input logic imr,
                              input logic dmr, input logic [2:0] st, input logic [12:0] dp,
                              input logic imreq, input logic dmreq, input logic irl,
                              input logic [3:0] rc, input logic il, input logic be);
    vec_t v;
    v.op = op; v.xo = xo; v.imr = imr; v.dmr = dmr; v.st = st; v.dp = dp;
    v.imreq = imreq; v.dmreq = dmreq; v.irl = irl; v.rc = rc; v.il = il; v.be = be;
    return v;
  endfunction

  function automatic logic [25:0] obs();
    return {o_state, o_dp_ctrl, mem.imem_req, mem.dmem_req, o_ir_load, o_pc_write,
            o_retire_cnt, o_illegal, o_bus_err};
  endfunction

  function automatic logic [25:0] expv(input vec_t v);
    return {v.st, v.dp, v.imreq, v.dmreq, v.irl, v.irl, v.rc, v.il, v.be};
  endfunction

  function automatic string fmt(input logic [25:0] v);
    return $sformatf("st=%0d dp=%b imreq=%b dmreq=%b irl=%b pcw=%b rc=%0d il=%b be=%b",
                     v[25:23], v[22:10], v[9], v[8], v[7], v[6], v[5:2], v[1], v[0]);
  endfunction

  task automatic drive(input vec_t v);
    i_opcode = v.op;
    i_xo = v.xo;
    mem.imem_ready = v.imr;
    mem.dmem_ready = v.dmr;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_opcode = 6'd0; i_xo = 10'd0; mem.imem_ready = 1'b0; mem.dmem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_opcode = 6'd0; i_xo = 10'd0; mem.imem_ready = 1'b1; mem.dmem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs() !== 26'd0) begin errors++; $display("FAIL reset_hold got %s exp all zero", fmt(obs())); end
    mem.imem_ready = 1'b0; mem.dmem_ready = 1'b0; rst = 1'b0; #1;
    checks++;
    if (obs() !== 26'd0) begin errors++; $display("FAIL reset_start got %s exp all zero", fmt(obs())); end
    @(posedge clk); #1;
    checks++;
    if (obs() !== expv(mk(6'd0, 10'd0, 1'b0, 1'b0, 3'd1, 13'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0))) begin
      errors++; $display("FAIL reset_to_fetch got %s exp st=1 imreq=1 rest zero", fmt(obs()));
    end
  endtask

  task automatic test_addi();
    vec_t tv[$];
    tv.push_back(mk(6'd14, 10'd10, 1'b1, 1'b0, 3'd1, 13'd0,      1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd10, 1'b0, 1'b0, 3'd2, 13'd0,      1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd10, 1'b0, 1'b0, 3'd3, E_ADDI,     1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd10, 1'b0, 1'b0, 3'd5, E_ADDI | RW, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd10, 1'b0, 1'b0, 3'd1, E_ADDI,     1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL addi[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_ld_wait();
    vec_t tv[$];
    tv.push_back(mk(6'd58, 10'd2, 1'b1, 1'b0, 3'd1, E_ADDI,          1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b1, 3'd2, E_ADDI,          1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd3, E_LD,            1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd4, E_LD | MR,       1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd4, E_LD | MR,       1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd4, E_LD | MR,       1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b1, 3'd4, E_LD | MR,       1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd5, E_LD | RW,       1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd1, E_LD,            1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL ld_wait[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_std();
    vec_t tv[$];
    tv.push_back(mk(6'd62, 10'd4, 1'b1, 1'b0, 3'd1, E_LD,       1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0));
    tv.push_back(mk(6'd62, 10'd4, 1'b1, 1'b0, 3'd2, E_LD,       1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
    tv.push_back(mk(6'd62, 10'd4, 1'b0, 1'b0, 3'd3, E_STD,      1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
    tv.push_back(mk(6'd62, 10'd4, 1'b0, 1'b1, 3'd4, E_STD | MW, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0));
    tv.push_back(mk(6'd62, 10'd4, 1'b0, 1'b0, 3'd1, E_STD,      1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL std[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_and_then_illegal();
    vec_t tv[$];
    tv.push_back(mk(6'd31, 10'd28, 1'b1, 1'b0, 3'd1, E_STD,      1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0));
    tv.push_back(mk(6'd31, 10'd28, 1'b0, 1'b0, 3'd2, E_STD,      1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0));
    tv.push_back(mk(6'd31, 10'd28, 1'b0, 1'b0, 3'd3, E_AND,      1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0));
    tv.push_back(mk(6'd31, 10'd28, 1'b0, 1'b0, 3'd5, E_AND | RW, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0));
    tv.push_back(mk(6'd0,  10'd0,  1'b1, 1'b0, 3'd1, E_AND,      1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0));
    tv.push_back(mk(6'd0,  10'd0,  1'b0, 1'b0, 3'd2, E_AND,      1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0));
    tv.push_back(mk(6'd0,  10'd0,  1'b0, 1'b0, 3'd7, E_AND,      1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0));
    tv.push_back(mk(6'd14, 10'd0,  1'b1, 1'b1, 3'd7, E_AND,      1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0));
    tv.push_back(mk(6'd14, 10'd0,  1'b1, 1'b1, 3'd7, E_AND,      1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL and_illegal[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_fetch_timeout();
    vec_t tv[$];
    apply_reset();
    for (int n = 0; n < 4; n++)
      tv.push_back(mk(6'd14, 10'd0, 1'b0, 1'b0, 3'd1, 13'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd0, 1'b0, 1'b0, 3'd7, 13'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    tv.push_back(mk(6'd14, 10'd0, 1'b1, 1'b0, 3'd7, 13'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL fetch_timeout[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_ready_at_timeout();
    vec_t tv[$];
    apply_reset();
    for (int n = 0; n < 3; n++)
      tv.push_back(mk(6'd14, 10'd0, 1'b0, 1'b0, 3'd1, 13'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd0, 1'b1, 1'b0, 3'd1, 13'd0,       1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd0, 1'b0, 1'b0, 3'd2, 13'd0,       1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd0, 1'b0, 1'b0, 3'd3, E_ADDI,      1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd0, 1'b0, 1'b0, 3'd5, E_ADDI | RW, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd14, 10'd0, 1'b0, 1'b0, 3'd1, E_ADDI,      1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL ready_at_timeout[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_alu_mix();
    vec_t        tv[$];
    logic [5:0]  op;
    logic [9:0]  xo;
    logic [12:0] dpn;
    logic [12:0] prev = E_ADDI;
    logic [3:0]  rc = 4'd1;
    for (int n = 0; n < 4; n++) begin
      case (n)
        0:       begin op = 6'd31; xo = 10'd40;  dpn = E_SUBF; end
        1:       begin op = 6'd31; xo = 10'd266; dpn = E_ADD;  end
        2:       begin op = 6'd28; xo = 10'd0;   dpn = E_ANDI; end
        default: begin op = 6'd24; xo = 10'd0;   dpn = E_ORI;  end
      endcase
      tv.push_back(mk(op, xo, 1'b1, 1'b0, 3'd1, prev,     1'b1, 1'b0, 1'b1, rc, 1'b0, 1'b0));
      tv.push_back(mk(op, xo, 1'b0, 1'b0, 3'd2, prev,     1'b0, 1'b0, 1'b0, rc, 1'b0, 1'b0));
      tv.push_back(mk(op, xo, 1'b0, 1'b0, 3'd3, dpn,      1'b0, 1'b0, 1'b0, rc, 1'b0, 1'b0));
      tv.push_back(mk(op, xo, 1'b0, 1'b0, 3'd5, dpn | RW, 1'b0, 1'b0, 1'b0, rc, 1'b0, 1'b0));
      prev = dpn;
      rc = rc + 4'd1;
    end
    tv.push_back(mk(6'd0, 10'd0, 1'b0, 1'b0, 3'd1, prev, 1'b1, 1'b0, 1'b0, rc, 1'b0, 1'b0));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL alu_mix[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_mem();
    vec_t tv[$];
    tv.push_back(mk(6'd58, 10'd2, 1'b1, 1'b0, 3'd1, E_ORI,     1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd2, E_ORI,     1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd3, E_LD,      1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0));
    tv.push_back(mk(6'd58, 10'd2, 1'b0, 1'b0, 3'd4, E_LD | MR, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL reset_mid_mem[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
    rst = 1'b1; #1;
    checks++;
    if (obs() !== 26'd0) begin errors++; $display("FAIL reset_mid_mem_async got %s exp all zero", fmt(obs())); end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++;
    if (obs() !== 26'd0) begin errors++; $display("FAIL reset_mid_mem_start got %s exp all zero", fmt(obs())); end
    @(posedge clk); #1;
    checks++;
    if (obs() !== expv(mk(6'd0, 10'd0, 1'b0, 1'b0, 3'd1, 13'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0))) begin
      errors++; $display("FAIL reset_mid_mem_fetch got %s exp st=1 imreq=1 rest zero", fmt(obs()));
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [3:0] exp_rc = 4'd0;
    i_opcode = 6'd14; i_xo = 10'd0; mem.dmem_ready = 1'b0;
    for (int n = 0; n < 16; n++) begin
      mem.imem_ready = 1'b1;
      @(posedge clk); #1;
      mem.imem_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      exp_rc = exp_rc + 4'd1;
      checks++;
      if ({o_state, o_retire_cnt} !== {3'd1, exp_rc}) begin
        errors++; $display("FAIL b2b_retire[%0d] got st=%0d rc=%0d exp st=1 rc=%0d", n, o_state, o_retire_cnt, exp_rc);
      end
    end
  endtask

  task automatic test_bad_xo();
    vec_t tv[$];
    apply_reset();
    tv.push_back(mk(6'd31, 10'd29, 1'b1, 1'b0, 3'd1, 13'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd31, 10'd29, 1'b0, 1'b0, 3'd2, 13'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    tv.push_back(mk(6'd31, 10'd29, 1'b0, 1'b0, 3'd7, 13'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    foreach (tv[k]) begin
      drive(tv[k]); #1;
      checks++;
      if (obs() !== expv(tv[k])) begin errors++; $display("FAIL bad_xo[%0d] got %s exp %s", k, fmt(obs()), fmt(expv(tv[k]))); end
      if (k < tv.size() - 1) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i_opcode = 6'd0;
    i_xo = 10'd0;
    mem.imem_ready = 1'b0;
    mem.dmem_ready = 1'b0;
    test_reset();
    test_addi();
    test_ld_wait();
    test_std();
    test_and_then_illegal();
    test_fetch_timeout();
    test_ready_at_timeout();
    test_alu_mix();
    test_reset_mid_mem();
    test_back_to_back_wrap();
    test_bad_xo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upower_multicycle_ctrl.md
# upower_multicycle_ctrl

Multi-cycle sequencer for the 64-bit uPower load/store/R/I datapath. It replaces the single-cycle control path with a FETCH/DECODE/EXEC/MEM/WB state machine and drives the register-file, ALU-mux and data-memory control lines. Instruction memory and data memory connect through req/ready handshakes with a bounded wait. It also counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles a req may wait for ready; minimum value 2.
- `CW`, default 32: width of `retire_cnt`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `opcode` in 6: `instruction[31:26]`, sampled from the IR in DECODE.
- `xo` in 10: `instruction[10:1]`, X/XO-form extended opcode.
- `imem_req` out 1: fetch request.
- `imem_ready` in 1: IR data valid this cycle.
- `dmem_req` out 1: data access request.
- `dmem_ready` in 1: data access done this cycle (read data valid for ld).
- `ir_load` out 1: latch IR.
- `pc_write` out 1: PC <= PC+4.
- `dp_ctrl` out 13: `{alu_op[3:0], reg_dst, reg1, reg2, alu_src, mem_to_reg, reg_write, mem_read, mem_write, imm_ds}`, bits 12..0.
- `state` out 3: current state, for debug.
- `illegal` out 1: sticky; undecodable opcode/XO.
- `bus_err` out 1: sticky; handshake timeout.
- `retire_cnt` out CW: count of retired instructions, wraps.

## Operation
- States: START=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. The state register resets to START.
- Decode classes (ALU_OP: and=0000, or=0001, add=0010, sub=0110):
  - op 31, xo 266 (add): 0010, reg_dst0 reg1 1 reg2 1 alu_src0.
  - op 31, xo 40 (subf): 0110, same muxing as add.
  - op 31, xo 28 (and): 0000, reg_dst1 reg1 0 reg2 1 alu_src0.
  - op 14 (addi): 0010, reg_dst0 reg1 1 alu_src1.
  - op 28 (andi): 0000, reg_dst1 reg1 0 alu_src1.
  - op 24 (ori): 0001, same muxing as andi.
  - op 58 (ld): 0010, reg_dst0 reg1 1 alu_src1 mem_to_reg1 imm_ds1.
  - op 62 (std): 0010, reg1 1 reg2 0 alu_src1 imm_ds1.
  - Any other opcode, or op 31 with any other xo: illegal.
- Mux/ALU fields (`alu_op`, `reg_dst`, `reg1`, `reg2`, `alu_src`, `mem_to_reg`, `imm_ds`) are registered in DECODE and held until the next DECODE. They are 0 after reset.
- Strobe fields: `reg_write` is 1 only in WB. `mem_read`/`mem_write` are 1 only in MEM for ld/std respectively. All strobes are 0 in every other state.
- START: all outputs 0; next state FETCH.
- FETCH: `imem_req`=1. On `imem_ready`: `ir_load`=1 and `pc_write`=1 for that cycle, then DECODE.
- DECODE: an illegal instruction sets `illegal` and goes to TRAP; otherwise EXEC.
- EXEC: one cycle. ld/std go to MEM; all others go to WB.
- MEM: `dmem_req`=1. On `dmem_ready`: ld goes to WB; std increments `retire_cnt` and goes to FETCH.
- WB: `reg_write`=1 for one cycle, `retire_cnt`++, then FETCH.
- TRAP: all strobes and reqs 0; state held until `rst`.

## Timing
- Minimum cycles per instruction, with ready in the first req cycle: ALU types 4, std 4, ld 5.
- Wait counter: cleared on entry to FETCH and to MEM; increments each req cycle without ready.
  - If the counter reaches MEM_TIMEOUT-1 with no ready: `bus_err`=1, next state TRAP.
  - Ready in the same cycle as the timeout: ready wins.
- req stays asserted continuously until ready. Ready while req is 0 is ignored.
- `retire_cnt` wraps from 2^CW-1 to 0.
- `rst` mid-instruction: immediate return to START. All outputs, `illegal`, `bus_err`, `retire_cnt` and the wait counter go to 0. No strobe is asserted in the reset cycle.
- Outputs are decoded from registered state plus registered fields. There are no combinational paths from `imem_ready`/`dmem_ready` to `dp_ctrl`. `ir_load`, `pc_write` and the state transition depend on ready combinationally.

## Structure
- Package `upower_ctrl_pkg`:
  - state encodings;
  - opcode constants 31/14/28/24/58/62;
  - XO constants 266/40/28;
  - ALU_OP codes;
  - `dp_ctrl` bit-index constants.
- Sub-module `upower_ctrl_decode`: combinational; maps (opcode, xo) to {mux fields, class ld/std/alu, legal}.
- Top level: FSM, wait counter, retire counter, strobe gating.

## Test plan
- addi R17,R0,20 (0x3A200014) with ready immediate:
  - states 1,2,3,5,1;
  - `dp_ctrl` fields alu_op 0010, alu_src 1, reg_dst 0;
  - `reg_write` high exactly 1 cycle;
  - `retire_cnt` 0→1.
- ld R1,1(R2) (0xE8220004) with `dmem_ready` delayed 3 cycles:
  - `dmem_req` high 4 cycles;
  - `mem_read` tracks `dmem_req`;
  - WB with `mem_to_reg`=1 and `imm_ds`=1;
  - total 8 cycles.
- std R5,2(R2) (0xF8A20008):
  - `mem_write` 1 cycle in MEM, `reg_write` never asserted;
  - FETCH follows MEM directly;
  - `retire_cnt` increments once.
- op 31 xo 28 (and R24,R6,R7) then opcode 0:
  - first instruction retires with reg_dst 1 and reg1 0;
  - second sets `illegal`=1, state 7 held, no strobes.
- With MEM_TIMEOUT=4, `imem_ready` never asserted: `bus_err`=1 after 4 FETCH cycles, then TRAP.
- Repeat the timeout case with ready arriving in cycle 4: no error, normal decode.
- Reset asserted mid-MEM of ld:
  - `dmem_req` and `mem_read` drop immediately;
  - all counters 0;
  - START→FETCH after release.
